hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline stall unit for the 5-stage MIPS core. It combines stall and flush generation with EX- and ID-stage forwarding-select generation. It adds two sequential trackers: a load-latency hold counter for multi-cycle data memory, and a busy tracker for the iterative multiply/divide unit (MDU). It sits beside the datapath and drives PC/IF-ID enables, the ID/EX flush, and forwarding muxes.

Parameters:
REG_W, 5, register-specifier width
LOAD_LAT, 1, cycles from load entering M until its data can be forwarded (>=1)
MDU_CYCLES, 32, MDU execution cycles from start to HI/LO valid (>=2)
CNT_W, 6, width of internal counters; must hold max(LOAD_LAT, MDU_CYCLES)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
RsD, RtD  in  REG_W  source specifiers in ID
RsE, RtE  in  REG_W  source specifiers in EX
WriteRegE, WriteRegM, WriteRegW  in  REG_W  destination specifiers in EX/MEM/WB
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage
MemtoRegE, MemtoRegM  in  1  load in EX / MEM
BranchD  in  1  branch resolving in ID
MduStartE  in  1  one-cycle pulse: MDU op in EX, starts MDU
MduUseD  in  1  ID instruction reads HI/LO or is an MDU op
StallF, StallD, FlushE  out  1  hold PC, hold IF/ID, bubble ID/EX
ForwardAD, ForwardBD  out  1  forward ALUOutM to ID comparator operands
ForwardAE, ForwardBE  out  2  EX operand select: 00 regfile, 01 ResultW, 10 ALUOutM
MduBusy  out  1  MDU tracker in BUSY

Behaviour:
- Reset is asynchronous: while rst_n=0, counters clear, MDU FSM goes to IDLE, and every output is 0.
- Register 0 never matches. Every comparison requires specifier != 0.
- ForwardAE: 10 if RegWriteM & WriteRegM==RsE; else 01 if RegWriteW & WriteRegW==RsE; else 00. MEM wins over WB. ForwardBE is the same using RtE.
- ForwardAD = RegWriteM & WriteRegM==RsD. ForwardBD = RegWriteM & WriteRegM==RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & [(RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})].
- Load hold counter ld_cnt:
  - When lwstall=1 and ld_cnt=0, load LOAD_LAT-1.
  - While ld_cnt>0, decrement each cycle; ld_hold = (ld_cnt!=0).
  - LOAD_LAT=1 means ld_hold is never asserted, matching the original 1-bubble behaviour.
- MDU FSM, two states:
  - IDLE: MduStartE=1 moves to BUSY and loads mdu_cnt=MDU_CYCLES-1.
  - BUSY: decrement mdu_cnt each cycle; at mdu_cnt==1, move to IDLE next edge. BUSY therefore lasts exactly MDU_CYCLES-1 cycles after the start edge.
  - MduStartE while BUSY is ignored; this is an illegal stimulus, flagged by an assertion.
  - mdu_stall = MduBusy & MduUseD.
- stall = lwstall | branchstall | ld_hold | mdu_stall. StallF = StallD = FlushE = stall, combinational from inputs and state, with zero-cycle latency.
- Simultaneous events: all stall sources OR together, and counters advance independently. A new lwstall while ld_cnt>0 does not reload the counter.
- Reset asserted mid-hold or mid-BUSY aborts immediately. After release, the unit is in IDLE with ld_cnt=0.

Decomposition:
- Package hazard_pkg holds:
  - REG_W default
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - MDU state encodings IDLE/BUSY
- Sub-module mdu_busy_tracker holds the FSM and mdu_cnt. Ports: clk, rst_n, start, busy; parameter MDU_CYCLES.
- Forwarding, stall OR, and ld_cnt stay in the top module.

Test Plan:
- Forwarding: RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8 -> ForwardAE=10. Set RegWriteM=0 -> 01. Set RsE=0 with WriteRegM=0 -> 00.
- Load-use with LOAD_LAT=3: MemtoRegE=1, RtE=9, RsD=9 for one cycle, then MemtoRegE=0 -> StallF/StallD/FlushE high for exactly 3 consecutive cycles.
- Branch: BranchD=1, RsD=4; RegWriteE=1, WriteRegE=4 -> stall=1. Next cycle MemtoRegM=1, WriteRegM=4 -> stall=1. Then ALU producer in M -> stall=0, ForwardAD=1.
- MDU with MDU_CYCLES=4: MduStartE pulse, MduUseD held 1 -> MduBusy and stall high for 3 cycles, then both 0. Same sequence with MduUseD=0 -> no stall.
- Reset mid-operation: assert rst_n=0 asynchronously (mid-clock) during BUSY with ld_cnt=2 -> all outputs 0 immediately. After release, no residual stall; a fresh MduStartE runs a full count.
- Overlap: lwstall and MDU stall together with LOAD_LAT=2, MDU_CYCLES=6 -> stall equals the OR of both windows, and each counter expires on its own schedule.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects and MDU tracker states.
package hazard_pkg;

  localparam int REG_W_DEF = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mduState_t;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks the iterative multiply/divide unit: busy for MDU_CYCLES-1 cycles after a start pulse.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int W = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;
  localparam logic [W-1:0] START_CNT = W'(MDU_CYCLES - 1);
  localparam logic [W-1:0] ONE       = W'(1);

  mduState_t state, stateNext;
  logic [W-1:0] cnt, cntNext;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // NOTE: defaults come first so no path through the case leaves a target unassigned (no latch).
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext = BUSY;
          cntNext   = START_CNT;
        end
      end
      BUSY: begin
        cntNext = cnt - ONE;
        if (cnt == ONE) stateNext = IDLE;
      end
    endcase
  end

  assign busy = (state == BUSY);

  // A second start while busy is dropped by the FSM; flag it as illegal stimulus.
  assert property (@(posedge clk) disable iff (!rst_n) !(start && state == BUSY))
    else $error("mdu_busy_tracker: start pulse while MDU busy");

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall, flush and forwarding control for the 5-stage MIPS pipeline, with a
// multi-cycle load hold counter and an MDU busy tracker.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int LOAD_LAT   = 1,
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MduStartE,
  input  logic             MduUseD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MduBusy
);

  logic             lwStall, branchStall, ldHold, mduBusyInt, mduStall, stall;
  logic [CNT_W-1:0] ldCnt;
  logic [1:0]       fwdAE, fwdBE;

  // $zero is hard-wired, so a write to it never creates a dependency.
  function automatic logic regHit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (src != '0) && (dst == src);
  endfunction

  // MEM is the younger producer and takes priority over WB.
  assign fwdAE = (RegWriteM && regHit(WriteRegM, RsE)) ? FWD_MEM :
                 (RegWriteW && regHit(WriteRegW, RsE)) ? FWD_WB  : FWD_NONE;
  assign fwdBE = (RegWriteM && regHit(WriteRegM, RtE)) ? FWD_MEM :
                 (RegWriteW && regHit(WriteRegW, RtE)) ? FWD_WB  : FWD_NONE;

  assign lwStall = MemtoRegE && (regHit(RtE, RsD) || regHit(RtE, RtD));

  assign branchStall = BranchD &&
    ((RegWriteE && (regHit(WriteRegE, RsD) || regHit(WriteRegE, RtD))) ||
     (MemtoRegM && (regHit(WriteRegM, RsD) || regHit(WriteRegM, RtD))));

  // Extra hold cycles beyond the single load-use bubble; a running count is never reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ldCnt <= '0;
    else if (ldCnt != '0)    ldCnt <= ldCnt - CNT_W'(1);
    else if (lwStall)        ldCnt <= CNT_W'(LOAD_LAT - 1);
  end

  assign ldHold = (ldCnt != '0);

  mdu_busy_tracker #(
    .MDU_CYCLES(MDU_CYCLES)
  ) uMduTracker (
    .clk  (clk),
    .rst_n(rst_n),
    .start(MduStartE),
    .busy (mduBusyInt)
  );

  assign mduStall = mduBusyInt && MduUseD;
  assign stall    = lwStall || branchStall || ldHold || mduStall;

  // Reset also silences the combinational paths, not just the registered state.
  assign StallF    = rst_n && stall;
  assign StallD    = rst_n && stall;
  assign FlushE    = rst_n && stall;
  assign ForwardAD = rst_n && RegWriteM && regHit(WriteRegM, RsD);
  assign ForwardBD = rst_n && RegWriteM && regHit(WriteRegM, RtD);
  assign ForwardAE = rst_n ? fwdAE : FWD_NONE;
  assign ForwardBE = rst_n ? fwdBE : FWD_NONE;
  assign MduBusy   = rst_n && mduBusyInt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: two configurations driven in parallel and
// compared against a window-based reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int LAT_A = 3;
  localparam int MC_A  = 4;
  localparam int LAT_B = 2;
  localparam int MC_B  = 6;

  logic       clk, rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, MduStartE, MduUseD;

  logic [1:0] stallF, stallD, flushE, fwdAD, fwdBD, mduBusy;
  logic [1:0] fwdAE [2];
  logic [1:0] fwdBE [2];

  int nTests = 0;
  int nFail  = 0;

  hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(LAT_A), .MDU_CYCLES(MC_A), .CNT_W(6)) dutA (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MduStartE(MduStartE), .MduUseD(MduUseD),
    .StallF(stallF[0]), .StallD(stallD[0]), .FlushE(flushE[0]),
    .ForwardAD(fwdAD[0]), .ForwardBD(fwdBD[0]),
    .ForwardAE(fwdAE[0]), .ForwardBE(fwdBE[0]), .MduBusy(mduBusy[0])
  );

  hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(LAT_B), .MDU_CYCLES(MC_B), .CNT_W(6)) dutB (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MduStartE(MduStartE), .MduUseD(MduUseD),
    .StallF(stallF[1]), .StallD(stallD[1]), .FlushE(flushE[1]),
    .ForwardAD(fwdAD[1]), .ForwardBD(fwdBD[1]),
    .ForwardAE(fwdAE[1]), .ForwardBE(fwdBE[1]), .MduBusy(mduBusy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: hold and busy are time windows [start+1, end) measured in cycles.
  int cyc;
  int holdEnd [2];
  int busyEnd [2];

  function automatic int latOf(int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int mcOf(int i);
    return (i == 0) ? MC_A : MC_B;
  endfunction

  function automatic logic same(logic [4:0] a, logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic refLw();
    return MemtoRegE && (same(RtE, RsD) || same(RtE, RtD));
  endfunction

  function automatic logic refBr();
    return BranchD && ((RegWriteE && (same(WriteRegE, RsD) || same(WriteRegE, RtD))) ||
                       (MemtoRegM && (same(WriteRegM, RsD) || same(WriteRegM, RtD))));
  endfunction

  function automatic logic [1:0] refFwd(logic [4:0] src);
    if (RegWriteM && same(WriteRegM, src)) return 2'b10;
    if (RegWriteW && same(WriteRegW, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] expVec(int i);
    logic hold, busy, st;
    if (!rst_n) return 10'd0;
    hold = (cyc < holdEnd[i]);
    busy = (cyc < busyEnd[i]);
    st   = refLw() | refBr() | hold | (busy & MduUseD);
    return {st, st, st, RegWriteM & same(WriteRegM, RsD), RegWriteM & same(WriteRegM, RtD),
            refFwd(RsE), refFwd(RtE), busy};
  endfunction

  function automatic logic [9:0] obsVec(int i);
    return {stallF[i], stallD[i], flushE[i], fwdAD[i], fwdBD[i], fwdAE[i], fwdBE[i], mduBusy[i]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        holdEnd[i] <= 0;
        busyEnd[i] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (refLw() && cyc >= holdEnd[i]) holdEnd[i] <= cyc + latOf(i);
        if (MduStartE && cyc >= busyEnd[i]) busyEnd[i] <= cyc + mcOf(i);
      end
    end
  end

  task automatic clearIn();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; MduStartE = 0; MduUseD = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RsE = 5'd8; RegWriteM = 1; WriteRegM = 5'd8; RsD = 5'd8; MemtoRegE = 1; RtE = 5'd8;
    BranchD = 1; MduUseD = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (obsVec(i) !== 10'd0) begin
        nFail++;
        $display("FAIL reset_outputs dut%0d: got %b want %b", i, obsVec(i), 10'd0);
      end
    end
    @(negedge clk);
    clearIn();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (obsVec(i) !== expVec(i)) begin
        nFail++;
        $display("FAIL reset_release dut%0d: got %b want %b", i, obsVec(i), expVec(i));
      end
    end
    tick();
  endtask

  task automatic test_forwarding();
    clearIn();
    RegWriteM = 1; WriteRegM = 5'd8; RegWriteW = 1; WriteRegW = 5'd8; RsE = 5'd8;
    #1;
    nTests++;
    if (fwdAE[0] !== FWD_MEM || fwdAE[1] !== FWD_MEM) begin
      nFail++;
      $display("FAIL fwd_mem_wins: ForwardAE got %b/%b want %b", fwdAE[0], fwdAE[1], FWD_MEM);
    end
    tick();
    RegWriteM = 0;
    #1;
    nTests++;
    if (fwdAE[0] !== FWD_WB || fwdAE[1] !== FWD_WB) begin
      nFail++;
      $display("FAIL fwd_wb: ForwardAE got %b/%b want %b", fwdAE[0], fwdAE[1], FWD_WB);
    end
    tick();
    RegWriteM = 1; WriteRegM = 5'd0; RsE = 5'd0;
    #1;
    nTests++;
    if (fwdAE[0] !== FWD_NONE || fwdAE[1] !== FWD_NONE) begin
      nFail++;
      $display("FAIL fwd_reg0: ForwardAE got %b/%b want %b", fwdAE[0], fwdAE[1], FWD_NONE);
    end
    tick();
    for (int k = 0; k < 40; k++) begin
      RsD = 5'($urandom_range(3, 0)); RtD = 5'($urandom_range(3, 0));
      RsE = 5'($urandom_range(3, 0)); RtE = 5'($urandom_range(3, 0));
      WriteRegM = 5'($urandom_range(3, 0)); WriteRegW = 5'($urandom_range(3, 0));
      RegWriteM = 1'($urandom_range(1, 0)); RegWriteW = 1'($urandom_range(1, 0));
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (obsVec(i) !== expVec(i)) begin
          nFail++;
          $display("FAIL fwd_random dut%0d step%0d: got %b want %b", i, k, obsVec(i), expVec(i));
        end
      end
      tick();
    end
    clearIn();
  endtask

  task automatic test_load_use();
    int cnt [2];
    cnt[0] = 0; cnt[1] = 0;
    clearIn();
    MemtoRegE = 1; RtE = 5'd9; RsD = 5'd9;
    for (int k = 0; k < 6; k++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (obsVec(i) !== expVec(i)) begin
          nFail++;
          $display("FAIL load_use dut%0d step%0d: got %b want %b", i, k, obsVec(i), expVec(i));
        end
        if (stallF[i] === 1'b1) cnt[i]++;
      end
      tick();
      clearIn();
    end
    nTests++;
    if (cnt[0] != LAT_A || cnt[1] != LAT_B) begin
      nFail++;
      $display("FAIL load_use_len: stall cycles got %0d/%0d want %0d/%0d", cnt[0], cnt[1], LAT_A, LAT_B);
    end
  endtask

  task automatic test_branch();
    clearIn();
    BranchD = 1; RsD = 5'd4; RegWriteE = 1; WriteRegE = 5'd4;
    #1;
    nTests++;
    if (stallF !== 2'b11 || flushE !== 2'b11) begin
      nFail++;
      $display("FAIL branch_alu_in_ex: stall got %b want 11", stallF);
    end
    tick();
    RegWriteE = 0; WriteRegE = 5'd0; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5'd4;
    #1;
    nTests++;
    if (stallF !== 2'b11 || stallD !== 2'b11) begin
      nFail++;
      $display("FAIL branch_load_in_mem: stall got %b want 11", stallF);
    end
    tick();
    MemtoRegM = 0;
    #1;
    nTests++;
    if (stallF !== 2'b00 || fwdAD !== 2'b11) begin
      nFail++;
      $display("FAIL branch_alu_in_mem: stall got %b fwdAD got %b want 00/11", stallF, fwdAD);
    end
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (obsVec(i) !== expVec(i)) begin
        nFail++;
        $display("FAIL branch_model dut%0d: got %b want %b", i, obsVec(i), expVec(i));
      end
    end
    tick();
    clearIn();
  endtask

  task automatic test_mdu(input logic use_d);
    int busyCnt [2];
    int stallCnt [2];
    busyCnt = '{0, 0};
    stallCnt = '{0, 0};
    clearIn();
    MduUseD = use_d; MduStartE = 1;
    for (int k = 0; k < 9; k++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (obsVec(i) !== expVec(i)) begin
          nFail++;
          $display("FAIL mdu use=%0b dut%0d step%0d: got %b want %b", use_d, i, k, obsVec(i), expVec(i));
        end
        if (mduBusy[i] === 1'b1) busyCnt[i]++;
        if (stallF[i] === 1'b1) stallCnt[i]++;
      end
      tick();
      MduStartE = 0;
    end
    nTests++;
    if (busyCnt[0] != MC_A - 1 || busyCnt[1] != MC_B - 1 ||
        stallCnt[0] != (use_d ? MC_A - 1 : 0) || stallCnt[1] != (use_d ? MC_B - 1 : 0)) begin
      nFail++;
      $display("FAIL mdu_len use=%0b: busy %0d/%0d stall %0d/%0d want busy %0d/%0d",
               use_d, busyCnt[0], busyCnt[1], stallCnt[0], stallCnt[1], MC_A - 1, MC_B - 1);
    end
    clearIn();
  endtask

  task automatic test_reset_mid();
    clearIn();
    MduStartE = 1; MemtoRegE = 1; RtE = 5'd9; RsD = 5'd9;
    tick();
    clearIn();
    #1;
    nTests++;
    if (stallF[0] !== 1'b1 || mduBusy !== 2'b11) begin
      nFail++;
      $display("FAIL mid_setup: stallA got %b busy got %b want 1/11", stallF[0], mduBusy);
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      nTests++;
      if (obsVec(i) !== 10'd0) begin
        nFail++;
        $display("FAIL mid_reset dut%0d: got %b want %b", i, obsVec(i), 10'd0);
      end
    end
    tick();
    rst_n = 1'b1;
    MduUseD = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (obsVec(i) !== 10'd0) begin
          nFail++;
          $display("FAIL post_reset dut%0d step%0d: got %b want %b", i, k, obsVec(i), 10'd0);
        end
      end
      tick();
    end
    test_mdu(1'b1);
  endtask

  task automatic test_overlap();
    int stallCnt [2];
    stallCnt = '{0, 0};
    clearIn();
    for (int k = 0; k < 10; k++) begin
      MduUseD = 1; MduStartE = (k == 0); MemtoRegE = (k == 5); RtE = 5'd5; RtD = 5'd5;
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (obsVec(i) !== expVec(i)) begin
          nFail++;
          $display("FAIL overlap dut%0d step%0d: got %b want %b", i, k, obsVec(i), expVec(i));
        end
        if (stallF[i] === 1'b1) stallCnt[i]++;
      end
      tick();
    end
    nTests++;
    if (stallCnt[0] != 6 || stallCnt[1] != 6) begin
      nFail++;
      $display("FAIL overlap_len: stall cycles got %0d/%0d want 6/6", stallCnt[0], stallCnt[1]);
    end
    clearIn();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      RsD = 5'($urandom_range(3, 0)); RtD = 5'($urandom_range(3, 0));
      RsE = 5'($urandom_range(3, 0)); RtE = 5'($urandom_range(3, 0));
      WriteRegE = 5'($urandom_range(3, 0)); WriteRegM = 5'($urandom_range(3, 0));
      WriteRegW = 5'($urandom_range(3, 0));
      RegWriteE = 1'($urandom_range(1, 0)); RegWriteM = 1'($urandom_range(1, 0));
      RegWriteW = 1'($urandom_range(1, 0)); MemtoRegM = 1'($urandom_range(1, 0));
      MemtoRegE = ($urandom_range(3, 0) == 0);
      BranchD   = ($urandom_range(2, 0) == 0);
      MduUseD   = 1'($urandom_range(1, 0));
      MduStartE = (cyc >= busyEnd[0]) && (cyc >= busyEnd[1]) && ($urandom_range(3, 0) == 0);
      #1;
      for (int i = 0; i < 2; i++) begin
        nTests++;
        if (obsVec(i) !== expVec(i)) begin
          nFail++;
          $display("FAIL random dut%0d step%0d: got %b want %b", i, k, obsVec(i), expVec(i));
        end
      end
      tick();
    end
    clearIn();
  endtask

  initial begin
    rst_n = 1'b0;
    clearIn();
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mdu(1'b1);
    test_mdu(1'b0);
    test_reset_mid();
    test_overlap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
